nibble_serial_adder: RTL and testbench

//   Sequential wide-operand adder built around the existing adder_4bit.
//   - Latches two NIBBLES*4-bit operands and a carry-in.
//   - Feeds one nibble pair per clock, LSB nibble first, into a single adder_4bit instance.
//   - Registers the carry between nibbles and assembles the full sum.
//   - Sits directly upstream/downstream of adder_4bit: drives its a/b/cin, consumes its sum/cout.

---
 rtl/nibble_serial_adder.sv | 106 ++++++++++
 tb/tb_nibble_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide add done one nibble per clock through a single adder_4bit slice

// adder_4bit: plain 4-bit ripple adder slice with carry in/out
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = a + b + {4'd0, cin};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
  logic [3:0]    add_sum;
  logic          add_cout;

  // The first slice takes the external carry-in; later slices take the registered ripple carry.
  adder_4bit u_add (
    .a    (a_q[4*idx_q +: 4]),
    .b    (b_q[4*idx_q +: 4]),
    .cin  ((idx_q == '0) ? cin_q : carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register; reset clears everything immediately, discarding any in-flight add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next state: RUN steps one nibble per edge; IDLE and DONE both accept a new start.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == RUN) begin
      sum_d[4*idx_q +: 4] = add_sum;
      carry_d = add_cout;
      idx_d   = idx_q + 1'b1;
      if (idx_q == LAST) begin
        cout_d  = add_cout;
        state_d = DONE;
      end
    end else if (start) begin
      a_d     = a;
      b_d     = b;
      cin_d   = cin;
      idx_d   = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: vector table, corner sequences and random vectors against an a+b+cin scoreboard
module tb_nibble_serial_adder;
  localparam int N = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, cin, busy, done, cout;
  logic [15:0] a, b, sum;
  logic [16:0] exp_q[$];
  int          checks = 0;
  int          fails = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pops the oldest expected {cout,sum}.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_done: got sum %0h with nothing expected", sum);
      end else begin
        chk("result", {15'd0, cout, sum}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic c);
    start = 1'b1;
    a = x;
    b = y;
    cin = c;
    exp_q.push_back({1'b0, x} + {1'b0, y} + {16'd0, c});
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (lat < 20 && !(lat > 0 && done)) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles", lat);
    end
  endtask

  task automatic run_add(input logic [15:0] x, input logic [15:0] y, input logic c, input bit timing);
    int lat, bc;
    @(posedge clk);
    #1;
    launch(x, y, c);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    if (timing) begin
      chk("latency", lat, N + 1);
      chk("busy_cycles", bc, N);
    end
  endtask

  initial begin
    vec_t tbl[4];
    int lat, bc, nd;
    tbl[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_add(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
      chk("tbl_sum", sum, tbl[i].sum);
      chk("tbl_cout", cout, tbl[i].cout);
    end
    launch(16'h0005, 16'h0003, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk("b2b_latency", lat, N + 1);
    chk("b2b_sum", sum, 16'h0008);
    @(posedge clk);
    #1;
    launch(16'h00F0, 16'h0010, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 16'hAAAA;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk("ignore_sum", sum, 16'h0100);
    chk("ignore_busy", bc, 2);
    @(posedge clk);
    #1;
    launch(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    run_add(16'h0101, 16'h0101, 1'b1, 1'b1);
    chk("fresh_sum", sum, 16'h0203);
    for (int i = 0; i < 200; i++)
      run_add(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
